// File: rtl/coleco_ctrl_pkg.sv
// coleco_ctrl_pkg
// Shared definitions for the ColecoVision controller scanner:
//   - scan FSM state encoding
//   - controller pin bit positions within the 7-bit pin vector
//   - CPU view (mode) encoding
//   - idle (nothing pressed) snapshot value and read-byte packing helper
package coleco_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM_DRV  = 3'd1,
    ST_ARM_SMP  = 3'd2,
    ST_GAP_A    = 3'd3,
    ST_FIRE_DRV = 3'd4,
    ST_FIRE_SMP = 3'd5,
    ST_GAP_F    = 3'd6
  } scan_state_t;

  // Pin vector order is {P9,P7,P6,P4,P3,P2,P1}
  localparam int PIN_P1   = 0;
  localparam int PIN_P2   = 1;
  localparam int PIN_P3   = 2;
  localparam int PIN_P4   = 3;
  localparam int PIN_P6   = 4;
  localparam int PIN_P7   = 5;
  localparam int PIN_P9   = 6;
  localparam int FIRE_BIT = PIN_P6;

  localparam logic MODE_KEYPAD = 1'b0;
  localparam logic MODE_JOY    = 1'b1;

  localparam logic [6:0] PINS_IDLE = 7'h7F;

  // CPU read byte: bit 7 is always high, remaining bits are the pins
  function automatic logic [7:0] pack_read(input logic [6:0] pins);
    return {1'b1, pins};
  endfunction

endpackage

// File: rtl/ctrl_debounce.sv
// ctrl_debounce
// One 7-bit controller snapshot. On each sample strobe the synchronized
// pins are offered; the stable snapshot changes only after DEBOUNCE_COUNT
// consecutive identical samples.
// Build option: CTRL_SCAN_DEBOUNCE_EN. When undefined, the snapshot simply
// takes every sample and DEBOUNCE_COUNT has no effect.
// Ports:
//   clk     system clock
//   rstn    asynchronous active-low reset
//   smp     one-cycle sample strobe
//   din     synchronized pin sample
//   stable  debounced snapshot
module ctrl_debounce
  import coleco_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       smp,
  input  logic [6:0] din,
  output logic [6:0] stable
);

`ifdef CTRL_SCAN_DEBOUNCE_EN
  localparam logic [3:0] DC4 = 4'(DEBOUNCE_COUNT);

  logic [6:0] cand;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;

  // Saturate so a long-held value never wraps back through DC4
  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cand   <= PINS_IDLE;
      cnt    <= 4'd0;
      stable <= PINS_IDLE;
    end else if (smp) begin
      if (din == cand) begin
        cnt <= cnt_inc;
        if (cnt_inc >= DC4) stable <= din;
      end else begin
        cand <= din;
        cnt  <= 4'd1;
        // A new value is already "DEBOUNCE_COUNT in a row" when the count is 1
        if (DEBOUNCE_COUNT == 1) stable <= din;
      end
    end
  end
`else
  logic [3:0] unused_dc;
  assign unused_dc = 4'(DEBOUNCE_COUNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stable <= PINS_IDLE;
    end else if (smp) begin
      stable <= din;
    end
  end
`endif

endmodule

// File: rtl/coleco_ctrl_scanner.sv
// coleco_ctrl_scanner
// Autonomous scanner for the shared controller common lines. Alternately
// pulls CP5 (joystick) and CP8 (keypad) low, lets the pins settle, samples
// both ports and keeps four debounced snapshots the CPU can read at any time.
// An interrupt is raised when either joystick fire button becomes pressed.
// Build option: CTRL_SCAN_DEBOUNCE_EN (see ctrl_debounce).
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   scan_en              run scanning (checked at the end of each scan pair)
//   mode_wr, mode_sel    CPU mode write (0 keypad view, 1 joystick view)
//   rd_req, rd_player    CPU read strobe and player select
//   rd_data, rd_valid    read byte and its one-cycle valid strobe
//   c1, c2               raw asynchronous controller pins, active low
//   cp5_arm, cp8_fire    registered common lines, active low
//   irq_n, irq_ack       level interrupt and its clear strobe
module coleco_ctrl_scanner
  import coleco_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scan_en,
  input  logic       mode_wr,
  input  logic       mode_sel,
  input  logic       rd_req,
  input  logic       rd_player,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic [6:0] c1,
  input  logic [6:0] c2,
  output logic       cp5_arm,
  output logic       cp8_fire,
  output logic       irq_n,
  input  logic       irq_ack
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  logic [6:0]  c1_meta, c1_sync, c2_meta, c2_sync;
  scan_state_t state, state_next;
  logic [CW-1:0] settle_cnt, settle_next;
  logic        cp5_next, cp8_next;
  logic        mode;
  logic [6:0]  snap [4];   // index {mode, player}: 0/1 fire p1/p2, 2/3 arm p1/p2
  logic [1:0]  fire_prev;
  logic [1:0]  fire_fall;
  logic        pending;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c1_meta <= PINS_IDLE;
      c1_sync <= PINS_IDLE;
      c2_meta <= PINS_IDLE;
      c2_sync <= PINS_IDLE;
    end else begin
      c1_meta <= c1;
      c1_sync <= c1_meta;
      c2_meta <= c2;
      c2_sync <= c2_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      cp5_arm    <= 1'b1;
      cp8_fire   <= 1'b1;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      cp5_arm    <= cp5_next;
      cp8_fire   <= cp8_next;
    end
  end

  always_comb begin
    state_next  = state;
    settle_next = '0;
    case (state)
      ST_IDLE:     if (scan_en) state_next = ST_ARM_DRV;
      ST_ARM_DRV: begin
        if (settle_cnt == SETTLE_LAST) state_next = ST_ARM_SMP;
        else settle_next = settle_cnt + 1'b1;
      end
      ST_ARM_SMP:  state_next = ST_GAP_A;
      ST_GAP_A:    state_next = ST_FIRE_DRV;
      ST_FIRE_DRV: begin
        if (settle_cnt == SETTLE_LAST) state_next = ST_FIRE_SMP;
        else settle_next = settle_cnt + 1'b1;
      end
      ST_FIRE_SMP: state_next = ST_GAP_F;
      ST_GAP_F:    state_next = scan_en ? ST_ARM_DRV : ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    // Commons are decoded from the next state so the registered outputs
    // line up exactly with the state they belong to; the gap states keep
    // the two lines from ever overlapping.
    cp5_next = !((state_next == ST_ARM_DRV)  || (state_next == ST_ARM_SMP));
    cp8_next = !((state_next == ST_FIRE_DRV) || (state_next == ST_FIRE_SMP));
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_snap
      logic smp_i;
      assign smp_i = (gi >= 2) ? (state == ST_ARM_SMP) : (state == ST_FIRE_SMP);
      ctrl_debounce #(
        .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
      ) u_deb (
        .clk    (clk),
        .rstn   (rstn),
        .smp    (smp_i),
        .din    ((gi % 2 == 1) ? c2_sync : c1_sync),
        .stable (snap[gi])
      );
    end
  endgenerate

  // Non-blocking update gives the read the pre-write mode and pre-update snapshot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data  <= 8'hFF;
      rd_valid <= 1'b0;
      mode     <= MODE_KEYPAD;
    end else begin
      rd_valid <= rd_req;
      if (rd_req)  rd_data <= pack_read(snap[{mode, rd_player}]);
      if (mode_wr) mode <= mode_sel;
    end
  end

  assign fire_fall = fire_prev & ~{snap[3][FIRE_BIT], snap[2][FIRE_BIT]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fire_prev <= 2'b11;
      pending   <= 1'b0;
    end else begin
      fire_prev <= {snap[3][FIRE_BIT], snap[2][FIRE_BIT]};
      if (|fire_fall)   pending <= 1'b1;
      else if (irq_ack) pending <= 1'b0;
    end
  end

  assign irq_n = ~pending;

endmodule

// File: tb/tb_coleco_ctrl_scanner.sv
module tb_coleco_ctrl_scanner;

`ifdef CTRL_SCAN_DEBOUNCE_EN
  localparam int EFF_DC = 4;
`else
  localparam int EFF_DC = 1;
`endif
  localparam int PERIOD = 36;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scan_en = 1'b0;
  logic       mode_wr = 1'b0;
  logic       mode_sel = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_player = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [6:0] c1 = 7'h7F;
  logic [6:0] c2 = 7'h7F;
  logic       cp5_arm;
  logic       cp8_fire;
  logic       irq_n;
  logic       irq_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: per snapshot, history of samples; stable takes a value
  // once the last EFF_DC samples all equal it.
  logic [6:0] m_stable [4];
  logic [6:0] m_hist [4][$];
  bit         m_pend;

  typedef struct {
    logic       msel;
    logic       player;
    logic [7:0] exp_data;
  } rd_vec_t;
  rd_vec_t tbl [4];

  coleco_ctrl_scanner dut (
    .clk       (clk),
    .rstn      (rstn),
    .scan_en   (scan_en),
    .mode_wr   (mode_wr),
    .mode_sel  (mode_sel),
    .rd_req    (rd_req),
    .rd_player (rd_player),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .c1        (c1),
    .c2        (c2),
    .cp5_arm   (cp5_arm),
    .cp8_fire  (cp8_fire),
    .irq_n     (irq_n),
    .irq_ack   (irq_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_level(input int sel, input logic lvl);
    int n = 0;
    while ((((sel == 0) ? cp5_arm : cp8_fire) !== lvl) && (n < 200)) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_common: sel %0d got %b want %b after %0d cycles",
               sel, (sel == 0) ? cp5_arm : cp8_fire, lvl, n);
    end
  endtask

  // Returns at the first negedge of a fresh low phase of the chosen common
  task automatic wait_start(input int sel);
    wait_level(sel, 1'b1);
    wait_level(sel, 1'b0);
  endtask

  task automatic set_mode(input logic m);
    mode_wr = 1'b1;
    mode_sel = m;
    tick();
    mode_wr = 1'b0;
  endtask

  task automatic do_read(input logic wr, input logic msel, input logic player,
                         input logic [7:0] exp_v, input string name);
    mode_wr = wr;
    mode_sel = msel;
    rd_req = 1'b1;
    rd_player = player;
    tick();
    mode_wr = 1'b0;
    rd_req = 1'b0;
    $display("read %s player=%0d data=%h valid=%b", name, player, rd_data, rd_valid);
    check({name, "_valid"}, {7'd0, rd_valid}, 8'd1);
    check(name, rd_data, exp_v);
    tick();
    check({name, "_strobe"}, {7'd0, rd_valid}, 8'd0);
    check({name, "_hold"}, rd_data, exp_v);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic model_sample(input int idx, input logic [6:0] v);
    bit same;
    m_hist[idx].push_back(v);
    if (m_hist[idx].size() > 16) void'(m_hist[idx].pop_front());
    same = (m_hist[idx].size() >= EFF_DC);
    for (int k = 1; k <= EFF_DC; k++)
      if (same && (m_hist[idx][m_hist[idx].size() - k] != v)) same = 1'b0;
    if (same) begin
      if ((idx >= 2) && m_stable[idx][4] && !v[4]) m_pend = 1'b1;
      m_stable[idx] = v;
    end
  endtask

  function automatic logic [6:0] mutate(input logic [6:0] p);
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return p;
    if (r < 8) return p ^ (7'h01 << $urandom_range(0, 6));
    return 7'($urandom);
  endfunction

  // One full scan pair: arm pins shown in the ARM phase, keypad pins in the FIRE phase
  task automatic run_round(input logic [6:0] a1, input logic [6:0] a2,
                           input logic [6:0] f1, input logic [6:0] f2, input bit chk);
    logic p;
    wait_start(0);
    c1 = a1;
    c2 = a2;
    if (chk) begin
      repeat (3) tick();
      p = 1'($urandom_range(0, 1));
      set_mode(1'b0);
      do_read(1'b0, 1'b0, p, {1'b1, m_stable[{1'b0, p}]}, "rnd_fire");
      check("rnd_irq_a", {7'd0, irq_n}, {7'd0, ~m_pend});
    end
    wait_start(1);
    model_sample(2, a1);
    model_sample(3, a2);
    c1 = f1;
    c2 = f2;
    if (chk) begin
      repeat (3) tick();
      p = 1'($urandom_range(0, 1));
      set_mode(1'b1);
      do_read(1'b0, 1'b0, p, {1'b1, m_stable[{1'b1, p}]}, "rnd_arm");
      check("rnd_irq_f", {7'd0, irq_n}, {7'd0, ~m_pend});
      if ($urandom_range(0, 2) == 0) pulse_ack();
    end
    wait_level(1, 1'b1);
    model_sample(0, f1);
    model_sample(1, f2);
  endtask

  initial begin
    logic [6:0] ra1, ra2, rf1, rf2;
    logic [6:0] tv [4];
    logic [6:0] tg;
    logic       e5, e8;
    int         ph;

    // ---- reset state ----
    tick();
    check("rst_cp5", {7'd0, cp5_arm}, 8'd1);
    check("rst_cp8", {7'd0, cp8_fire}, 8'd1);
    check("rst_rd_data", rd_data, 8'hFF);
    check("rst_rd_valid", {7'd0, rd_valid}, 8'd0);
    check("rst_irq_n", {7'd0, irq_n}, 8'd1);
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      set_mode(1'(i / 2));
      do_read(1'b0, 1'b0, 1'(i % 2), 8'hFF, "rst_snap");
    end

    // ---- scan schedule, three full periods ----
    scan_en = 1'b1;
    tick();
    check("scan_start", {7'd0, cp5_arm}, 8'd0);
    for (int t = 0; t < 3 * PERIOD; t++) begin
      ph = t % PERIOD;
      e5 = (ph < 17) ? 1'b0 : 1'b1;
      e8 = (ph >= 18 && ph < 35) ? 1'b0 : 1'b1;
      check("sched", {6'd0, cp5_arm, cp8_fire}, {6'd0, e5, e8});
      tick();
    end

    // ---- toggling arm pin: never stable with debounce, follows without ----
    set_mode(1'b1);
    for (int k = 0; k < 5; k++) begin
      tg = (k % 2 == 0) ? 7'h7E : 7'h7F;
      run_round(tg, 7'h7F, 7'h7F, 7'h7F, 1'b0);
      do_read(1'b0, 1'b0, 1'b0, (EFF_DC == 1) ? {1'b1, tg} : 8'hFF, "toggle");
    end

    // ---- fire press on player 1 raises irq the cycle after the snapshot ----
    for (int k = 1; k <= EFF_DC; k++) begin
      wait_start(0);
      c1 = 7'h6F;
      c2 = 7'h7F;
      wait_level(0, 1'b1);
      check("irq_hold", {7'd0, irq_n}, 8'd1);
      tick();
      check("irq_edge", {7'd0, irq_n}, (k == EFF_DC) ? 8'd0 : 8'd1);
      c1 = 7'h7F;
      do_read(1'b0, 1'b0, 1'b0, (k == EFF_DC) ? 8'hEF : 8'hFF, "irq_snap");
    end
    pulse_ack();
    check("irq_ack", {7'd0, irq_n}, 8'd1);

    // ---- load known snapshots, park the scanner, then table reads ----
    for (int k = 0; k <= EFF_DC; k++)
      run_round(7'h35, 7'h5B, 7'h1C, 7'h72, 1'b0);
    scan_en = 1'b0;
    tick();
    for (int t = 0; t < 40; t++) begin
      check("parked", {6'd0, cp5_arm, cp8_fire}, 8'd3);
      tick();
    end
    tbl[0] = '{msel: 1'b0, player: 1'b0, exp_data: 8'h9C};
    tbl[1] = '{msel: 1'b0, player: 1'b1, exp_data: 8'hF2};
    tbl[2] = '{msel: 1'b1, player: 1'b0, exp_data: 8'hB5};
    tbl[3] = '{msel: 1'b1, player: 1'b1, exp_data: 8'hDB};
    for (int i = 0; i < 4; i++) begin
      set_mode(tbl[i].msel);
      do_read(1'b0, 1'b0, tbl[i].player, tbl[i].exp_data, "table");
    end

    // ---- mode write in the read cycle uses the old mode ----
    set_mode(1'b0);
    do_read(1'b1, 1'b1, 1'b0, 8'h9C, "same_cyc_old");
    do_read(1'b0, 1'b0, 1'b0, 8'hB5, "same_cyc_new");

    // ---- randomized rounds against the model ----
    tv[0] = 7'h1C; tv[1] = 7'h72; tv[2] = 7'h35; tv[3] = 7'h5B;
    for (int i = 0; i < 4; i++) begin
      m_hist[i].delete();
      repeat (EFF_DC) m_hist[i].push_back(tv[i]);
      m_stable[i] = tv[i];
    end
    pulse_ack();
    ra1 = tv[2]; ra2 = tv[3]; rf1 = tv[0]; rf2 = tv[1];
    scan_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      ra1 = mutate(ra1);
      ra2 = mutate(ra2);
      rf1 = mutate(rf1);
      rf2 = mutate(rf2);
      run_round(ra1, ra2, rf1, rf2, 1'b1);
    end

    // ---- force a pending irq, then reset during FIRE_DRV ----
    for (int k = 0; k < EFF_DC; k++) run_round(7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    pulse_ack();
    for (int k = 0; k < EFF_DC; k++) run_round(7'h6F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    check("irq_set2", {7'd0, irq_n}, 8'd0);
    wait_start(1);
    repeat (4) tick();
    check("fire_drv", {7'd0, cp8_fire}, 8'd0);
    scan_en = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("arst_cp8", {7'd0, cp8_fire}, 8'd1);
    check("arst_cp5", {7'd0, cp5_arm}, 8'd1);
    check("arst_irq_n", {7'd0, irq_n}, 8'd1);
    check("arst_rd_data", rd_data, 8'hFF);
    check("arst_rd_valid", {7'd0, rd_valid}, 8'd0);
    repeat (3) tick();
    rstn = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      check("post_rst_idle", {6'd0, cp5_arm, cp8_fire}, 8'd3);
    end
    set_mode(1'b1);
    do_read(1'b0, 1'b0, 1'b0, 8'hFF, "post_rst_snap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coleco_ctrl_scanner.md
Name: coleco_ctrl_scanner

Overview:
Autonomous scheduler for the shared controller common lines (CP5_ARM joystick select, CP8_FIRE keypad select) of the portable ColecoVision glue.
- Alternately drives each common line low, waits for the pins to settle, samples both controller ports (7 pins each) and debounces them into four stable snapshots.
- The CPU side, decoded from IO ports 0x80/0xC0 (mode write) and 0xFC/0xFF (read), gets immediate snapshot reads with no controller-timing dependency.
- Raises an interrupt on a debounced fire press.

Parameters:
- SETTLE_CYCLES, 16, clk cycles a common line is held low before sampling; minimum 3, covers the synchronizer.
- DEBOUNCE_COUNT, 4, consecutive identical samples required to update a stable snapshot; range 1..15.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- scan_en  in  1  1 = scanning runs; 0 = scanner parks in IDLE
- mode_wr  in  1  one-cycle strobe, CPU write to mode port
- mode_sel  in  1  with mode_wr: 0 = keypad (FIRE) view, 1 = joystick (ARM) view
- rd_req  in  1  one-cycle strobe, CPU read of controller port
- rd_player  in  1  0 = player 1, 1 = player 2
- rd_data  out  8  read byte {1'b1, P9,P7,P6,P4,P3,P2,P1}
- rd_valid  out  1  one-cycle strobe, rd_data valid
- c1  in  7  player 1 pins {P9,P7,P6,P4,P3,P2,P1}, asynchronous, active low
- c2  in  7  player 2 pins, same order
- cp5_arm  out  1  joystick common, active low
- cp8_fire  out  1  keypad common, active low
- irq_n  out  1  active-low interrupt, level
- irq_ack  in  1  one-cycle strobe, clears pending interrupt

Behaviour:
Reset values:
- cp5_arm = 1, cp8_fire = 1, rd_data = 8'hFF, rd_valid = 0, irq_n = 1.
- mode = keypad (0).
- All four snapshots and debounce candidates = 7'h7F; counters = 0; FSM = IDLE.

Input synchronisation:
- c1/c2 pass through a 2-flop synchronizer before any use.

FSM (settle counter 0..SETTLE_CYCLES-1):
- IDLE: both commons high. Go to ARM_DRV when scan_en = 1.
- ARM_DRV: cp5_arm = 0. After SETTLE_CYCLES cycles go to ARM_SMP.
- ARM_SMP: cp5_arm = 0. Capture synced c1/c2 into the arm debouncers. Go to GAP_A.
- GAP_A: both commons high (break-before-make). Go to FIRE_DRV.
- FIRE_DRV / FIRE_SMP / GAP_F: same as the ARM states, using cp8_fire and the fire debouncers. After GAP_F go to ARM_DRV, or to IDLE if scan_en = 0.
- scan_en is checked only in GAP_F, so a started scan pair always completes.
- Full cycle length = 2*(SETTLE_CYCLES+2) clk cycles.
- cp5_arm and cp8_fire are never low in the same cycle.
- Both commons are registered outputs.

Debounce (per snapshot: arm_p1, arm_p2, fire_p1, fire_p2):
- If sample == candidate: cnt saturates-increments.
- Otherwise: candidate <= sample, cnt <= 1.
- stable <= candidate when cnt reaches DEBOUNCE_COUNT (the sample that makes DEBOUNCE_COUNT consecutive equal samples).
- DEBOUNCE_COUNT = 1: stable updates on every sample.

Mode register:
- Updated on mode_wr.
- Affects read selection only, never scanning.

Read:
- rd_valid is asserted the cycle after rd_req.
- rd_data = {1'b1, stable[mode][rd_player]}, using mode and snapshots as they were in the rd_req cycle.
- rd_req and mode_wr in the same cycle: the read uses the old mode.
- A snapshot update in the same cycle as rd_req: the read returns the old snapshot.
- rd_data holds its value until the next read.

Interrupt:
- pending is set when arm_p1 or arm_p2 stable bit P6 (bit 4, fire) goes 1 -> 0.
- irq_n = ~pending.
- irq_ack clears pending.
- Set and ack in the same cycle: set wins.

Reset mid-scan:
- Asynchronously returns every output to its reset value immediately, including releasing both commons.

Optional Feature:
- CTRL_SCAN_DEBOUNCE_EN defined: debounce exactly as above.
- Not defined: no candidates or counters; stable <= sample directly in the SMP state; DEBOUNCE_COUNT is ignored.
- Scan timing, read and IRQ are identical either way.

Decomposition:
- Package coleco_ctrl_pkg holds:
  - FSM state encoding constants;
  - pin bit-index constants (P1..P9, FIRE_BIT = 4);
  - MODE_KEYPAD = 0 and MODE_JOY = 1;
  - idle snapshot value 7'h7F.
- Sub-module ctrl_debounce: one 7-bit debouncer with sample strobe, sample in, stable out, and the macro guard inside. Instantiated 4 times.

Test Plan:
- Reset then scan_en = 1, SETTLE_CYCLES = 16 -> cp5_arm low 17 cycles, 1 gap, cp8_fire low 17 cycles, 1 gap, repeat with period 36; the commons are never low together.
- c1 = 7'h6F (P6 low) held through ARM phases, DEBOUNCE_COUNT = 4 -> arm_p1 stable = 7'h6F after the 4th ARM_SMP; irq_n falls the next cycle; irq_ack -> irq_n = 1.
- c1 toggles 7'h7E/7'h7F every scan -> stable stays 7'h7F with the macro; follows the last sample without the macro.
- mode_wr with mode_sel = 0, c2 = 7'h72 in FIRE phases, rd_req with rd_player = 1 -> rd_valid the next cycle, rd_data = 8'hF2.
- mode_wr (mode_sel = 1) and rd_req in the same cycle -> data from the keypad snapshot; the following read returns the joystick snapshot.
- rstn asserted during FIRE_DRV -> cp8_fire = 1 and irq_n = 1 immediately; after release with scan_en = 0, the FSM stays IDLE with both commons high.
